param_timer: RTL

PARAM_TIMER -- requirements
Module: param_timer

---
 rtl/param_timer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/param_timer.sv
// Prescaled up/down timer with wrap, saturate and one-shot terminal behaviour.
// Drives registered terminal-count and compare pulses, plus a busy flag while running.
module param_timer #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned PRE_W = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [PRE_W-1:0] prescale,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             match,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   w_count_nxt;
    logic [PRE_W-1:0]   r_pre_cnt;
    logic [PRE_W-1:0]   w_pre_nxt;
    logic               r_tc;
    logic               w_tc_nxt;
    logic               r_match;
    logic               w_match_nxt;
    logic               r_busy;
    logic               w_terminal;

    assign w_terminal = dir ? (r_count == '0) : (r_count >= limit);

    // State register
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, prescaler and counter update; load overrides any tick
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_pre_nxt   = r_pre_cnt;
        w_tc_nxt    = 1'b0;
        w_match_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_pre_cnt != prescale) begin
                    w_pre_nxt = r_pre_cnt + PRE_W'(1);
                end else begin
                    w_pre_nxt = '0;
                    if (w_terminal) begin
                        w_tc_nxt = 1'b1;
                        if (mode == MODE_ONESHOT) begin
                            w_state_nxt = ST_DONE;
                        end else if (mode != MODE_SAT) begin
                            w_count_nxt = dir ? limit : '0;
                        end
                    end else begin
                        w_count_nxt = dir ? (r_count - WIDTH'(1)) : (r_count + WIDTH'(1));
                    end
                    w_match_nxt = (w_count_nxt == cmp_val);
                end
            end
            default: begin
            end
        endcase

        if (load) begin
            w_count_nxt = load_val;
            w_pre_nxt   = '0;
            w_tc_nxt    = 1'b0;
            w_match_nxt = 1'b0;
            w_state_nxt = (r_state == ST_DONE) ? ST_IDLE : r_state;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock) begin
        if (rst) begin
            r_count   <= '0;
            r_pre_cnt <= '0;
            r_tc      <= 1'b0;
            r_match   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_pre_cnt <= w_pre_nxt;
            r_tc      <= w_tc_nxt;
            r_match   <= w_match_nxt;
            r_busy    <= (w_state_nxt == ST_RUN);
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign match = r_match;
    assign busy  = r_busy;

endmodule
